pico_int_ctrl: RTL and testbench
================================

PICO_INT_CTRL -- requirements
Module: pico_int_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'hE0, the port_id of register 0; registers occupy BASE_ADDR+0..+2.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-low; reset==0 at a rising clk edge resets the block.
REQ-004 SHALL have port irq_in, input, 8 bits: interrupt sources, synchronous to clk, rising-edge sensitive.
REQ-005 SHALL have port port_id, input, 8 bits: processor I/O address.
REQ-006 SHALL have port write_strobe, input, 1 bit: processor output-write qualifier.
REQ-007 SHALL have port out_port, input, 8 bits: processor write data.
REQ-008 SHALL have port in_port, output, 8 bits: registered read data to the processor input mux.
REQ-009 SHALL have port rd_sel, output, 1 bit: registered, high when the previous-cycle port_id fell in BASE_ADDR..BASE_ADDR+2.
REQ-010 SHALL have port interrupt, output, 1 bit: interrupt request to the processor.
REQ-011 SHALL have port interrupt_ack, input, 1 bit: processor acknowledge.

Function
REQ-012 SHALL detect a rising edge on each irq_in[i] by comparing with a 1-cycle-delayed copy; a detected edge sets PEND[i] on the next edge.
REQ-013 SHALL hold an 8-bit MASK register (1 = enabled); pending bits latch regardless of MASK.
REQ-014 SHALL implement register map: +0 PEND (read; write-1-to-clear), +1 MASK (read/write), +2 VECTOR (read-only: bit7 = in-service valid, bits2:0 = in-service index, other bits 0).
REQ-015 SHALL perform writes when write_strobe==1 and port_id matches; writes to +2 or unmapped addresses SHALL be ignored.
REQ-016 SHALL, when an edge-set and a W1C clear hit the same PEND bit in the same cycle, leave the bit set.
REQ-017 SHALL update in_port and rd_sel every cycle from port_id (1-cycle latency); unmapped address gives in_port = 8'h00, rd_sel = 0.
REQ-018 SHALL implement states IDLE, ASSERT, SERVICE.
REQ-019 IDLE: when (PEND & MASK) != 0, SHALL latch the lowest set index as in-service index, set VECTOR valid, and go to ASSERT.
REQ-020 ASSERT: interrupt SHALL be 1 exactly while in ASSERT; on interrupt_ack==1 SHALL go to SERVICE (interrupt low the next cycle).
REQ-021 SERVICE: SHALL stay until PEND[in-service index]==0, then go to IDLE and clear VECTOR valid; VECTOR index SHALL retain its last value.
REQ-022 SHALL ignore interrupt_ack outside ASSERT.
REQ-023 SHALL not change the in-service index in ASSERT/SERVICE, even if a higher-priority (lower-index) source becomes pending; it SHALL be taken from IDLE afterwards.
REQ-024 SHALL, if software clears the in-service PEND bit while in ASSERT, remain in ASSERT until ack, then exit SERVICE on the following cycle.
REQ-025 SHALL, with a masked-only pending set, remain in IDLE; unmasking SHALL trigger REQ-019 on the next cycle.
REQ-026 Minimum latency from irq_in rising to interrupt==1 SHALL be 3 cycles (edge detect, PEND set, ASSERT entry).

Reset
REQ-027 On reset==0: PEND=0, MASK=0, VECTOR=0, edge-detect history=0, state=IDLE, interrupt=0, in_port=0, rd_sel=0.
REQ-028 Reset asserted in any state, including mid-ASSERT, SHALL drop interrupt on the next edge; ack afterward is ignored.
REQ-029 An irq_in level already high when reset releases SHALL not create an edge until it goes low then high.

Verification
REQ-030 MASK=8'hFF, pulse irq_in[5] -> PEND=8'h20, interrupt high 3 cycles later; ack -> interrupt low, VECTOR reads 8'h85; write 8'h20 to +0 -> IDLE, VECTOR=8'h05.
REQ-031 MASK=8'hFF, irq_in[6] and irq_in[2] rise same cycle -> VECTOR=8'h82; after clearing bit 2, second interrupt with VECTOR=8'h86.
REQ-032 MASK=8'h00, pulse irq_in[0] -> PEND=8'h01, interrupt stays 0; write MASK=8'h01 -> interrupt asserts next cycle.
REQ-033 Edge on irq_in[3] coinciding with W1C write 8'h08 to +0 -> PEND[3] reads 1.
REQ-034 Reset low during ASSERT -> interrupt 0 next cycle, all registers read 0; read of BASE_ADDR+3 -> in_port 8'h00, rd_sel 0.

Source files
------------

// File: rtl/pico_int_ctrl.sv
// PicoBlaze-style interrupt controller: rising-edge capture into PEND, MASK gating,
// lowest-index priority with an IDLE/ASSERT/SERVICE handshake, and a registered read port.
module pico_int_ctrl #(
    parameter logic [7:0] BASE_ADDR = 8'hE0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] irq_in,
    input  logic [7:0] port_id,
    input  logic       write_strobe,
    input  logic [7:0] out_port,
    output logic [7:0] in_port,
    output logic       rd_sel,
    output logic       interrupt,
    input  logic       interrupt_ack
);

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        SERVICE
    } state_t;

    localparam logic [7:0] PEND_ADDR = BASE_ADDR;
    localparam logic [7:0] MASK_ADDR = BASE_ADDR + 8'd1;

    state_t     state;
    state_t     state_next;
    logic [7:0] irq_prev;
    logic       hist_valid;
    logic [7:0] edge_q;
    logic [7:0] pend;
    logic [7:0] mask;
    logic [7:0] active;
    logic [2:0] first_idx;
    logic       vec_valid;
    logic       valid_next;
    logic [2:0] vec_idx;
    logic [2:0] idx_next;
    logic [7:0] vector;
    logic [7:0] offset;
    logic       addr_hit;
    logic       wr_pend;
    logic       wr_mask;

    assign offset   = port_id - BASE_ADDR;
    assign addr_hit = (offset < 8'd3);
    assign wr_pend  = write_strobe && (port_id == PEND_ADDR);
    assign wr_mask  = write_strobe && (port_id == MASK_ADDR);
    assign active   = pend & mask;
    assign vector   = {vec_valid, 4'b0000, vec_idx};
    assign interrupt = (state == ASSERT);

    // hist_valid keeps a level that is already high at reset release from looking like an edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_prev   <= 8'h00;
            hist_valid <= 1'b0;
            edge_q     <= 8'h00;
        end else begin
            irq_prev   <= irq_in;
            hist_valid <= 1'b1;
            edge_q     <= hist_valid ? (irq_in & ~irq_prev) : 8'h00;
        end
    end

    // A new edge wins over a write-1-to-clear of the same bit
    always_ff @(posedge clk) begin
        if (!reset) begin
            pend <= 8'h00;
            mask <= 8'h00;
        end else begin
            pend <= (pend & ~(wr_pend ? out_port : 8'h00)) | edge_q;
            if (wr_mask) begin
                mask <= out_port;
            end
        end
    end

    always_comb begin
        first_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (active[i]) begin
                first_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            vec_valid <= 1'b0;
            vec_idx   <= 3'd0;
        end else begin
            state     <= state_next;
            vec_valid <= valid_next;
            vec_idx   <= idx_next;
        end
    end

    // The in-service index is only chosen in IDLE, so later higher-priority sources wait
    always_comb begin
        state_next = state;
        valid_next = vec_valid;
        idx_next   = vec_idx;
        case (state)
            IDLE: begin
                if (|active) begin
                    idx_next   = first_idx;
                    valid_next = 1'b1;
                    state_next = ASSERT;
                end
            end
            ASSERT: begin
                if (interrupt_ack) begin
                    state_next = SERVICE;
                end
            end
            SERVICE: begin
                if (!pend[vec_idx]) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_port <= 8'h00;
            rd_sel  <= 1'b0;
        end else begin
            rd_sel <= addr_hit;
            case (offset)
                8'd0:    in_port <= pend;
                8'd1:    in_port <= mask;
                8'd2:    in_port <= vector;
                default: in_port <= 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_pico_int_ctrl.sv
// Testbench for pico_int_ctrl: directed scenarios with fixed expectations, then random
// traffic compared every cycle against a cycle-level behavioural model.
module tb_pico_int_ctrl;

    localparam logic [7:0] BASE = 8'hE0;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] irq_in = 8'h00;
    logic [7:0] port_id = 8'h00;
    logic       write_strobe = 1'b0;
    logic [7:0] out_port = 8'h00;
    logic       interrupt_ack = 1'b0;
    logic [7:0] in_port;
    logic       rd_sel;
    logic       interrupt;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] rdata;

    // Behavioural model state: phase 0 = idle, 1 = requesting, 2 = being serviced
    logic [7:0] m_pend = 8'h00;
    logic [7:0] m_mask = 8'h00;
    logic [7:0] m_edges = 8'h00;
    logic [7:0] m_last_irq = 8'h00;
    bit         m_seen = 1'b0;
    int         m_phase = 0;
    int         m_idx = 0;
    bit         m_valid = 1'b0;
    logic [7:0] m_in_port = 8'h00;
    bit         m_rd_sel = 1'b0;
    logic [7:0] m_vec;
    logic [7:0] m_active;
    int         m_off;

    pico_int_ctrl #(.BASE_ADDR(BASE)) dut (
        .clk          (clk),
        .reset        (reset),
        .irq_in       (irq_in),
        .port_id      (port_id),
        .write_strobe (write_strobe),
        .out_port     (out_port),
        .in_port      (in_port),
        .rd_sel       (rd_sel),
        .interrupt    (interrupt),
        .interrupt_ack(interrupt_ack)
    );

    always #5 clk = ~clk;

    // One clock: advance the model with the inputs seen at the rising edge, settle at the falling edge
    task automatic cycle();
        @(posedge clk);
        if (!reset) begin
            m_pend = 8'h00; m_mask = 8'h00; m_edges = 8'h00; m_last_irq = 8'h00;
            m_seen = 1'b0; m_phase = 0; m_idx = 0; m_valid = 1'b0;
            m_in_port = 8'h00; m_rd_sel = 1'b0;
        end else begin
            m_vec = {m_valid, 4'b0000, 3'(m_idx)};
            m_off = int'(port_id) - int'(BASE);
            m_rd_sel = (m_off >= 0 && m_off <= 2);
            if (m_off == 0) m_in_port = m_pend;
            else if (m_off == 1) m_in_port = m_mask;
            else if (m_off == 2) m_in_port = m_vec;
            else m_in_port = 8'h00;
            m_active = m_pend & m_mask;
            if (m_phase == 0) begin
                if (m_active != 8'h00) begin
                    for (int i = 0; i < 8; i++) begin
                        if (m_active[i]) begin
                            m_idx = i;
                            break;
                        end
                    end
                    m_valid = 1'b1;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (interrupt_ack) m_phase = 2;
            end else begin
                if (m_pend[m_idx] == 1'b0) begin
                    m_phase = 0;
                    m_valid = 1'b0;
                end
            end
            if (write_strobe && port_id == BASE) m_pend = m_pend & ~out_port;
            m_pend = m_pend | m_edges;
            if (write_strobe && port_id == BASE + 8'd1) m_mask = out_port;
            m_edges = m_seen ? (irq_in & ~m_last_irq) : 8'h00;
            m_last_irq = irq_in;
            m_seen = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic write_reg(input logic [7:0] off, input logic [7:0] data);
        port_id = BASE + off;
        out_port = data;
        write_strobe = 1'b1;
        cycle();
        write_strobe = 1'b0;
    endtask

    task automatic read_reg(input logic [7:0] off, output logic [7:0] data);
        port_id = BASE + off;
        write_strobe = 1'b0;
        cycle();
        data = in_port;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        irq_in = 8'hFF;
        port_id = BASE;
        cycle();
        cycle();
        n_checks++;
        if (interrupt !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_interrupt: got %b expected 0", interrupt); end
        n_checks++;
        if (in_port !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_in_port: got %h expected 00", in_port); end
        n_checks++;
        if (rd_sel !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rd_sel: got %b expected 0", rd_sel); end
        reset = 1'b1;
        cycle();
        write_reg(8'd1, 8'hFF);
        repeat (4) cycle();
        n_checks++;
        if (interrupt !== 1'b0) begin n_fail++; $display("[TB] FAIL held_level_no_irq: got %b expected 0", interrupt); end
        read_reg(8'd0, rdata);
        n_checks++;
        if (rdata !== 8'h00) begin n_fail++; $display("[TB] FAIL held_level_pend: got %h expected 00", rdata); end
        n_checks++;
        if (rd_sel !== 1'b1) begin n_fail++; $display("[TB] FAIL rd_sel_mapped: got %b expected 1", rd_sel); end
        irq_in = 8'h00;
        cycle();
        irq_in = 8'h80;
        cycle();
        cycle();
        read_reg(8'd0, rdata);
        n_checks++;
        if (rdata !== 8'h80) begin n_fail++; $display("[TB] FAIL rearm_pend: got %h expected 80", rdata); end
        n_checks++;
        if (interrupt !== 1'b1) begin n_fail++; $display("[TB] FAIL rearm_interrupt: got %b expected 1", interrupt); end
        interrupt_ack = 1'b1;
        cycle();
        interrupt_ack = 1'b0;
        write_reg(8'd0, 8'h80);
        irq_in = 8'h00;
        cycle();
        cycle();
    endtask

    task automatic test_single_irq();
        write_reg(8'd1, 8'hFF);
        irq_in = 8'h20;
        cycle();
        irq_in = 8'h00;
        n_checks++;
        if (interrupt !== 1'b0) begin n_fail++; $display("[TB] FAIL latency_1: got %b expected 0", interrupt); end
        cycle();
        n_checks++;
        if (interrupt !== 1'b0) begin n_fail++; $display("[TB] FAIL latency_2: got %b expected 0", interrupt); end
        cycle();
        n_checks++;
        if (interrupt !== 1'b1) begin n_fail++; $display("[TB] FAIL latency_3: got %b expected 1", interrupt); end
        read_reg(8'd0, rdata);
        n_checks++;
        if (rdata !== 8'h20) begin n_fail++; $display("[TB] FAIL single_pend: got %h expected 20", rdata); end
        interrupt_ack = 1'b1;
        cycle();
        interrupt_ack = 1'b0;
        n_checks++;
        if (interrupt !== 1'b0) begin n_fail++; $display("[TB] FAIL ack_drops_irq: got %b expected 0", interrupt); end
        read_reg(8'd2, rdata);
        n_checks++;
        if (rdata !== 8'h85) begin n_fail++; $display("[TB] FAIL vector_in_service: got %h expected 85", rdata); end
        write_reg(8'd0, 8'h20);
        cycle();
        read_reg(8'd2, rdata);
        n_checks++;
        if (rdata !== 8'h05) begin n_fail++; $display("[TB] FAIL vector_after_service: got %h expected 05", rdata); end
        n_checks++;
        if (interrupt !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_after_service: got %b expected 0", interrupt); end
    endtask

    task automatic test_priority();
        irq_in = 8'h44;
        cycle();
        irq_in = 8'h00;
        cycle();
        cycle();
        n_checks++;
        if (interrupt !== 1'b1) begin n_fail++; $display("[TB] FAIL prio_first_irq: got %b expected 1", interrupt); end
        read_reg(8'd2, rdata);
        n_checks++;
        if (rdata !== 8'h82) begin n_fail++; $display("[TB] FAIL prio_vector_low: got %h expected 82", rdata); end
        interrupt_ack = 1'b1;
        cycle();
        interrupt_ack = 1'b0;
        write_reg(8'd0, 8'h04);
        cycle();
        cycle();
        n_checks++;
        if (interrupt !== 1'b1) begin n_fail++; $display("[TB] FAIL prio_second_irq: got %b expected 1", interrupt); end
        read_reg(8'd2, rdata);
        n_checks++;
        if (rdata !== 8'h86) begin n_fail++; $display("[TB] FAIL prio_vector_high: got %h expected 86", rdata); end
        interrupt_ack = 1'b1;
        cycle();
        interrupt_ack = 1'b0;
        write_reg(8'd0, 8'h40);
        cycle();
        read_reg(8'd0, rdata);
        n_checks++;
        if (rdata !== 8'h00) begin n_fail++; $display("[TB] FAIL prio_pend_clear: got %h expected 00", rdata); end
    endtask

    task automatic test_masked();
        write_reg(8'd1, 8'h00);
        irq_in = 8'h01;
        cycle();
        irq_in = 8'h00;
        repeat (4) cycle();
        n_checks++;
        if (interrupt !== 1'b0) begin n_fail++; $display("[TB] FAIL masked_no_irq: got %b expected 0", interrupt); end
        read_reg(8'd0, rdata);
        n_checks++;
        if (rdata !== 8'h01) begin n_fail++; $display("[TB] FAIL masked_pend: got %h expected 01", rdata); end
        write_reg(8'd1, 8'h01);
        n_checks++;
        if (interrupt !== 1'b0) begin n_fail++; $display("[TB] FAIL unmask_same_cycle: got %b expected 0", interrupt); end
        cycle();
        n_checks++;
        if (interrupt !== 1'b1) begin n_fail++; $display("[TB] FAIL unmask_next_cycle: got %b expected 1", interrupt); end
        interrupt_ack = 1'b1;
        cycle();
        interrupt_ack = 1'b0;
        write_reg(8'd0, 8'h01);
        cycle();
        cycle();
    endtask

    task automatic test_w1c_collision();
        irq_in = 8'h08;
        cycle();
        irq_in = 8'h00;
        port_id = BASE;
        out_port = 8'h08;
        write_strobe = 1'b1;
        cycle();
        write_strobe = 1'b0;
        read_reg(8'd0, rdata);
        n_checks++;
        if (rdata !== 8'h08) begin n_fail++; $display("[TB] FAIL collision_set_wins: got %h expected 08", rdata); end
        write_reg(8'd0, 8'h08);
        read_reg(8'd0, rdata);
        n_checks++;
        if (rdata !== 8'h00) begin n_fail++; $display("[TB] FAIL w1c_clears: got %h expected 00", rdata); end
    endtask

    task automatic test_no_preempt();
        write_reg(8'd1, 8'hFF);
        irq_in = 8'h10;
        cycle();
        irq_in = 8'h00;
        cycle();
        cycle();
        n_checks++;
        if (interrupt !== 1'b1) begin n_fail++; $display("[TB] FAIL preempt_first_irq: got %b expected 1", interrupt); end
        irq_in = 8'h02;
        cycle();
        irq_in = 8'h00;
        cycle();
        read_reg(8'd2, rdata);
        n_checks++;
        if (rdata !== 8'h84) begin n_fail++; $display("[TB] FAIL no_preempt_vector: got %h expected 84", rdata); end
        write_reg(8'd0, 8'h10);
        n_checks++;
        if (interrupt !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_until_ack: got %b expected 1", interrupt); end
        interrupt_ack = 1'b1;
        cycle();
        interrupt_ack = 1'b0;
        n_checks++;
        if (interrupt !== 1'b0) begin n_fail++; $display("[TB] FAIL early_clear_ack: got %b expected 0", interrupt); end
        cycle();
        cycle();
        n_checks++;
        if (interrupt !== 1'b1) begin n_fail++; $display("[TB] FAIL deferred_irq: got %b expected 1", interrupt); end
        read_reg(8'd2, rdata);
        n_checks++;
        if (rdata !== 8'h81) begin n_fail++; $display("[TB] FAIL deferred_vector: got %h expected 81", rdata); end
        interrupt_ack = 1'b1;
        cycle();
        interrupt_ack = 1'b0;
        write_reg(8'd0, 8'h02);
        cycle();
        cycle();
    endtask

    task automatic test_reset_mid_assert();
        irq_in = 8'h02;
        cycle();
        irq_in = 8'h00;
        cycle();
        cycle();
        n_checks++;
        if (interrupt !== 1'b1) begin n_fail++; $display("[TB] FAIL pre_reset_irq: got %b expected 1", interrupt); end
        reset = 1'b0;
        cycle();
        n_checks++;
        if (interrupt !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_drops_irq: got %b expected 0", interrupt); end
        reset = 1'b1;
        interrupt_ack = 1'b1;
        cycle();
        interrupt_ack = 1'b0;
        n_checks++;
        if (interrupt !== 1'b0) begin n_fail++; $display("[TB] FAIL ack_after_reset: got %b expected 0", interrupt); end
        for (int k = 0; k < 3; k++) begin
            read_reg(8'(k), rdata);
            n_checks++;
            if (rdata !== 8'h00) begin n_fail++; $display("[TB] FAIL reg_after_reset_%0d: got %h expected 00", k, rdata); end
        end
        read_reg(8'd3, rdata);
        n_checks++;
        if (rdata !== 8'h00) begin n_fail++; $display("[TB] FAIL unmapped_data: got %h expected 00", rdata); end
        n_checks++;
        if (rd_sel !== 1'b0) begin n_fail++; $display("[TB] FAIL unmapped_rd_sel: got %b expected 0", rd_sel); end
    endtask

    task automatic test_random();
        reset = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0) irq_in = irq_in ^ 8'($urandom);
            case ($urandom_range(0, 4))
                0: port_id = BASE;
                1: port_id = BASE + 8'd1;
                2: port_id = BASE + 8'd2;
                3: port_id = BASE + 8'd3;
                default: port_id = 8'($urandom);
            endcase
            write_strobe = ($urandom_range(0, 3) == 0);
            out_port = 8'($urandom);
            interrupt_ack = ($urandom_range(0, 2) == 0);
            reset = ($urandom_range(0, 149) != 0);
            cycle();
            n_checks++;
            if (interrupt !== (m_phase == 1)) begin n_fail++; $display("[TB] FAIL rand_interrupt @%0d: got %b expected %b", n, interrupt, (m_phase == 1)); end
            n_checks++;
            if (in_port !== m_in_port) begin n_fail++; $display("[TB] FAIL rand_in_port @%0d: got %h expected %h", n, in_port, m_in_port); end
            n_checks++;
            if (rd_sel !== m_rd_sel) begin n_fail++; $display("[TB] FAIL rand_rd_sel @%0d: got %b expected %b", n, rd_sel, m_rd_sel); end
        end
        reset = 1'b1;
        write_strobe = 1'b0;
        interrupt_ack = 1'b0;
    endtask

    initial begin
        $display("[TB] starting pico_int_ctrl bench");
        test_reset();
        test_single_irq();
        test_priority();
        test_masked();
        test_w1c_collision();
        test_no_preempt();
        test_reset_mid_assert();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
